ram_dvi_sync_core: RTL and testbench

- Pixel-streaming stage between the frame-RAM reader and the DVI transmitter, in the pixel clock domain.
- Takes 256-pixel blocks (6144 bits) from the RAM side and replays them one 24-bit pixel per clock during active video.
- Active video is derived from externally supplied horizontal (rows) and vertical (lines) counters.
- Issues a one-cycle block request (ram_ask) and a frame-restart pulse (new_frame) to the RAM reader.

---
 rtl/ram_dvi_sync_core.sv | 115 +++++++++++
 tb/tb_ram_dvi_sync_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dvi_sync_core.sv
// Pixel replay stage between the frame-RAM reader and the DVI transmitter.
// Latches 256-pixel blocks and streams one 24-bit pixel per active-video clock.
module ram_dvi_sync_core #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic          clk75,
  input  logic          reset,
  input  logic [6143:0] pixel_data,
  input  logic [10:0]   rows,
  input  logic [10:0]   lines,
  output logic          new_frame,
  output logic [7:0]    debug,
  output logic          ram_ask,
  output logic [23:0]   rgb
);

  localparam int NPIX = 256;
  localparam int PW   = 24;
  localparam int BW   = NPIX * PW;

  logic [BW-1:0] display_q, display_d;
  logic [7:0]    idx_q, idx_d;
  logic [3:0]    blk_q, blk_d;
  logic          primed_q, primed_d;
  logic [PW-1:0] rgb_q, rgb_d;
  logic          ask_pend_q, ask_pend_d;
  logic          ram_ask_q, ram_ask_d;
  logic          new_frame_q, new_frame_d;
  logic          active_q, active_d;

  logic          active;
  logic          prime_start;
  logic          prime_load;
  logic          block_load;

  // Pixel 0 sits in the MSBs of the block.
  logic [PW-1:0] pix [NPIX];
  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
      assign pix[gi] = display_q[BW-1-PW*gi -: PW];
    end
  endgenerate

  always_comb begin
    active      = (rows < 11'(H_ACTIVE)) && (lines < 11'(V_ACTIVE));
    prime_start = (rows == 11'd0) && (lines == 11'(V_ACTIVE));
    prime_load  = (rows == 11'd0) && (lines == 11'(V_ACTIVE + 1));
    // Until a frame has been primed the display stays cleared, so output is black.
    block_load  = active && primed_q && (idx_q == 8'hff);

    display_d   = display_q;
    idx_d       = idx_q;
    blk_d       = blk_q;
    primed_d    = primed_q;
    rgb_d       = '0;
    new_frame_d = 1'b0;
    ask_pend_d  = 1'b0;
    ram_ask_d   = ask_pend_q;
    active_d    = active;

    if (active) begin
      rgb_d = pix[idx_q];
      idx_d = idx_q + 8'd1;
    end

    // Priming takes priority over an ordinary block turnover.
    if (prime_start) begin
      new_frame_d = 1'b1;
      idx_d       = 8'd0;
      blk_d       = 4'd0;
      primed_d    = 1'b0;
      ask_pend_d  = 1'b1;
    end else if (prime_load) begin
      display_d  = pixel_data;
      primed_d   = 1'b1;
      blk_d      = 4'd1;
      ask_pend_d = 1'b1;
    end else if (block_load) begin
      display_d  = pixel_data;
      blk_d      = blk_q + 4'd1;
      ask_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk75 or negedge reset) begin
    if (!reset) begin
      display_q   <= '0;
      idx_q       <= '0;
      blk_q       <= '0;
      primed_q    <= 1'b0;
      rgb_q       <= '0;
      ask_pend_q  <= 1'b0;
      ram_ask_q   <= 1'b0;
      new_frame_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      display_q   <= display_d;
      idx_q       <= idx_d;
      blk_q       <= blk_d;
      primed_q    <= primed_d;
      rgb_q       <= rgb_d;
      ask_pend_q  <= ask_pend_d;
      ram_ask_q   <= ram_ask_d;
      new_frame_q <= new_frame_d;
      active_q    <= active_d;
    end
  end

  assign rgb       = rgb_q;
  assign ram_ask   = ram_ask_q;
  assign new_frame = new_frame_q;
  assign debug     = {active_q, ram_ask_q, new_frame_q, primed_q, blk_q};

endmodule

// File: tb/tb_ram_dvi_sync_core.sv
// Directed bench for ram_dvi_sync_core: reset, priming, pixel order, block turnover, blanking.
module tb_ram_dvi_sync_core;

  logic          clk75;
  logic          reset;
  logic [6143:0] pixel_data;
  logic [10:0]   rows;
  logic [10:0]   lines;
  logic          new_frame;
  logic [7:0]    debug;
  logic          ram_ask;
  logic [23:0]   rgb;

  int n_checks = 0;
  int n_fail   = 0;

  ram_dvi_sync_core #(.H_ACTIVE(1024), .V_ACTIVE(768)) dut (
    .clk75      (clk75),
    .reset      (reset),
    .pixel_data (pixel_data),
    .rows       (rows),
    .lines      (lines),
    .new_frame  (new_frame),
    .debug      (debug),
    .ram_ask    (ram_ask),
    .rgb        (rgb)
  );

  initial clk75 = 1'b0;
  always #5 clk75 = ~clk75;

  // Block 0 is the 32-pixel group pattern; other blocks carry a tag and pixel number.
  function automatic logic [23:0] exp_pix(input int b, input int k);
    if (b == 0) begin
      if (k % 32 == 0)      return 24'h05ff00;
      else if (k % 32 == 5) return 24'h09ff00;
      else                  return 24'h00ff00;
    end
    return {8'(b), 8'(k), 8'h5a};
  endfunction

  function automatic logic [6143:0] pat(input int b);
    logic [6143:0] v;
    v = '0;
    for (int k = 0; k < 256; k++) v[6143-24*k -: 24] = exp_pix(b, k);
    return v;
  endfunction

  task automatic step(input int r, input int l);
    rows  = 11'(r);
    lines = 11'(l);
    @(posedge clk75);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if (rgb !== 24'h0 || ram_ask !== 1'b0 || new_frame !== 1'b0 || debug !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: rgb=%h ram_ask=%b new_frame=%b debug=%h, required all 0",
               tag, rgb, ram_ask, new_frame, debug);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    rows       = 11'd0;
    lines      = 11'd0;
    pixel_data = pat(3);
    #2;
    check_all_zero("reset_async");
    @(posedge clk75); #1;
    check_all_zero("reset_hold1");
    @(posedge clk75); #1;
    check_all_zero("reset_hold2");
    rows  = 11'd1100;
    lines = 11'd100;
    reset = 1'b1;
    step(1100, 100);
    check_all_zero("reset_release");
    $display("test_reset: rgb=%h debug=%h", rgb, debug);
  endtask

  task automatic test_priming();
    pixel_data = pat(0);
    step(0, 768);
    n_checks++;
    if (new_frame !== 1'b1 || ram_ask !== 1'b0 || debug !== 8'h20) begin
      n_fail++;
      $display("FAIL prime_start: new_frame=%b ram_ask=%b debug=%h, required 1 0 20", new_frame, ram_ask, debug);
    end
    step(1, 768);
    n_checks++;
    if (new_frame !== 1'b0 || ram_ask !== 1'b1 || debug !== 8'h40 || rgb !== 24'h0) begin
      n_fail++;
      $display("FAIL prime_ask0: new_frame=%b ram_ask=%b debug=%h rgb=%h, required 0 1 40 000000",
               new_frame, ram_ask, debug, rgb);
    end
    step(2, 768);
    n_checks++;
    if (ram_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL prime_ask0_width: ram_ask=%b, required 0", ram_ask);
    end
    step(0, 769);
    n_checks++;
    if (debug !== 8'h11 || ram_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL prime_load: debug=%h ram_ask=%b, required 11 0", debug, ram_ask);
    end
    step(1, 769);
    n_checks++;
    if (ram_ask !== 1'b1 || debug !== 8'h51) begin
      n_fail++;
      $display("FAIL prime_ask1: ram_ask=%b debug=%h, required 1 51", ram_ask, debug);
    end
    step(2, 769);
    n_checks++;
    if (ram_ask !== 1'b0 || rgb !== 24'h0) begin
      n_fail++;
      $display("FAIL prime_ask1_width: ram_ask=%b rgb=%h, required 0 000000", ram_ask, rgb);
    end
    $display("test_priming: debug=%h", debug);
  endtask

  task automatic check_group_pixels(input int r, input string tag);
    logic [23:0] want;
    want = 24'h00ff00;
    if (r == 0 || r == 32) want = 24'h05ff00;
    if (r == 5)            want = 24'h09ff00;
    n_checks++;
    if (rgb !== want) begin
      n_fail++;
      $display("FAIL %s rows=%0d: rgb=%h, required %h", tag, r, rgb, want);
    end
  endtask

  task automatic test_stream();
    int          g;
    int          n_ask;
    logic        act;
    logic        ld;
    logic        prev_ld;
    logic [3:0]  exp_blk;
    logic [23:0] exp_rgb;
    prev_ld = 1'b0;
    n_ask   = 0;
    exp_blk = 4'd1;
    for (int l = 0; l < 2; l++) begin
      for (int r = 0; r < ((l == 0) ? 1402 : 300); r++) begin
        act = (r < 1024);
        g   = l * 1024 + r;
        if (act && (g % 256 == 20)) pixel_data = pat(g / 256 + 1);
        step(r, l);
        ld = act && (g % 256 == 255);
        if (ld) exp_blk = exp_blk + 4'd1;
        exp_rgb = act ? exp_pix(g / 256, g % 256) : 24'h0;
        n_checks++;
        if (rgb !== exp_rgb) begin
          n_fail++;
          $display("FAIL stream_rgb line=%0d rows=%0d: rgb=%h, required %h", l, r, rgb, exp_rgb);
        end
        n_checks++;
        if (ram_ask !== prev_ld) begin
          n_fail++;
          $display("FAIL stream_ask line=%0d rows=%0d: ram_ask=%b, required %b", l, r, ram_ask, prev_ld);
        end
        if (ram_ask === 1'b1 && l == 0) n_ask++;
        if (ld) begin
          n_checks++;
          if (debug[3:0] !== exp_blk) begin
            n_fail++;
            $display("FAIL stream_blk line=%0d rows=%0d: blk=%0d, required %0d", l, r, debug[3:0], exp_blk);
          end
        end
        if (l == 0 && (r == 0 || r == 1 || r == 5 || r == 32)) check_group_pixels(r, "pixel_order");
        if (l == 0 && (r == 0 || r == 1024)) begin
          n_checks++;
          if (debug[7] !== act) begin
            n_fail++;
            $display("FAIL active_d rows=%0d: debug[7]=%b, required %b", r, debug[7], act);
          end
        end
        prev_ld = ld;
      end
    end
    n_checks++;
    if (n_ask != 4) begin
      n_fail++;
      $display("FAIL asks_per_line: got %0d pulses, required 4", n_ask);
    end
    $display("test_stream: %0d ram_ask pulses on line 0", n_ask);
  endtask

  task automatic test_vblank();
    for (int l = 770; l < 774; l++) begin
      step(100, l);
      n_checks++;
      if (rgb !== 24'h0) begin
        n_fail++;
        $display("FAIL vblank line=%0d: rgb=%h, required 000000", l, rgb);
      end
    end
    $display("test_vblank: rgb=%h", rgb);
  endtask

  task automatic test_reset_mid_line();
    pixel_data = pat(7);
    for (int r = 490; r < 500; r++) step(r, 10);
    rows  = 11'd500;
    reset = 1'b0;
    #1;
    check_all_zero("midline_async");
    step(500, 10);
    check_all_zero("midline_hold1");
    step(501, 10);
    check_all_zero("midline_hold2");
    reset = 1'b1;
    for (int r = 502; r < 1402; r++) begin
      step(r, 10);
      n_checks++;
      if (rgb !== 24'h0) begin
        n_fail++;
        $display("FAIL midline_black rows=%0d: rgb=%h, required 000000", r, rgb);
      end
    end
    pixel_data = pat(0);
    step(0, 768);
    n_checks++;
    if (new_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_reprime: new_frame=%b, required 1", new_frame);
    end
    step(1, 768);
    step(0, 769);
    step(1, 769);
    for (int r = 0; r < 40; r++) begin
      step(r, 0);
      if (r == 0 || r == 1 || r == 5 || r == 32) check_group_pixels(r, "midline_resume");
    end
    $display("test_reset_mid_line: rgb=%h", rgb);
  endtask

  initial begin
    test_reset();
    test_priming();
    test_stream();
    test_vblank();
    test_reset_mid_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
